// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers of the 5-stage core:
// stage occupancy states, per-stage bundle widths and control bit-field offsets.
package pipe_pkg;

    // Occupancy encoding doubles as the OCCUPANCY output value.
    typedef enum logic [1:0] {
        STAGE_EMPTY = 2'd0,
        STAGE_ONE   = 2'd1,
        STAGE_FULL  = 2'd2
    } stage_state_t;

    // Per-stage bundle widths.
    localparam int PIPE_CTRL_W   = 8;
    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_DATA_W  = 101;
    localparam int EX_MEM_DATA_W = 101;
    localparam int MEM_WB_DATA_W = 101;

    // Control bundle field offsets.
    localparam int CTRL_REG_WRITE_BIT  = 0;
    localparam int CTRL_MEM_TO_REG_LSB = 1;  // 2 bits
    localparam int CTRL_MEM_READ_LSB   = 3;  // 3 bits

    // Assemble a control bundle from its named fields; unused upper bits stay zero.
    function automatic logic [PIPE_CTRL_W-1:0] pack_ctrl(
        input logic       reg_write,
        input logic [1:0] mem_to_reg,
        input logic [2:0] mem_read
    );
        logic [PIPE_CTRL_W-1:0] c;
        c = '0;
        c[CTRL_REG_WRITE_BIT]          = reg_write;
        c[CTRL_MEM_TO_REG_LSB +: 2]    = mem_to_reg;
        c[CTRL_MEM_READ_LSB +: 3]      = mem_read;
        return c;
    endfunction

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating counter of stalled cycles for one pipeline stage.
// Synchronous active-low reset; holds at all-ones once saturated.
module pipe_stall_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             stall,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Count stalled cycles, stopping at the maximum value.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
        if (!RESET) begin
            count <= '0;
        end else if (stall && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/pipeline_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Head slot drives the outputs; skid slot absorbs the entry accepted while downstream stalls.
// FLUSH turns all held entries into bubbles; bubbles always present an all-zero control bundle.
// Optional feature: define PIPE_STALL_CNT_EN to build the saturating stall counter.
module pipeline_stage_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = EX_MEM_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [CTRL_W-1:0] IN_CTRL,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [CTRL_W-1:0] OUT_CTRL,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [1:0]        OCCUPANCY,
    output logic [CNT_W-1:0]  STALL_CNT
);

    stage_state_t      state_q, state_d;
    logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
    logic [DATA_W-1:0] head_data, skid_data;
    logic              in_fire, out_fire;
    logic              head_load_in, head_load_skid, skid_load;

    // Ready depends only on registered state and reset, never on OUT_READY.
    assign IN_READY  = RESET && (state_q != STAGE_FULL);
    assign OUT_VALID = (state_q != STAGE_EMPTY);
    assign in_fire   = IN_VALID && IN_READY;
    assign out_fire  = OUT_VALID && OUT_READY;
    assign OUT_CTRL  = head_ctrl & {CTRL_W{OUT_VALID}};
    assign OUT_DATA  = head_data;
    assign OCCUPANCY = state_q;

    // Next-state and slot load enables; flush discards any same-cycle accept.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d        = state_q;
        head_load_in   = 1'b0;
        head_load_skid = 1'b0;
        skid_load      = 1'b0;
        if (FLUSH) begin
            state_d = STAGE_EMPTY;
        end else begin
            case (state_q)
                STAGE_EMPTY: begin
                    if (in_fire) begin
                        head_load_in = 1'b1;
                        state_d      = STAGE_ONE;
                    end
                end
                STAGE_ONE: begin
                    if (in_fire && out_fire) begin
                        head_load_in = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                        state_d   = STAGE_FULL;
                    end else if (out_fire) begin
                        state_d = STAGE_EMPTY;
                    end
                end
                STAGE_FULL: begin
                    if (out_fire) begin
                        head_load_skid = 1'b1;
                        state_d        = STAGE_ONE;
                    end
                end
                default: state_d = STAGE_EMPTY;
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= STAGE_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Head slot: loads from upstream or from the skid slot; cleared by reset so OUT_DATA reads 0.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            head_ctrl <= '0;
            head_data <= '0;
        end else if (head_load_in) begin
            head_ctrl <= IN_CTRL;
            head_data <= IN_DATA;
        end else if (head_load_skid) begin
            head_ctrl <= skid_ctrl;
            head_data <= skid_data;
        end
    end

    // Skid slot: captures the entry accepted while the head is stalled.
    always_ff @(posedge CLK) begin
        // NOTE: the skid slot has no reset; it is never observed until loaded under a valid state.
        if (skid_load) begin
            skid_ctrl <= IN_CTRL;
            skid_data <= IN_DATA;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic stall;
    assign stall = OUT_VALID && !OUT_READY;

    pipe_stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .CLK   (CLK),
        .RESET (RESET),
        .stall (stall),
        .count (STALL_CNT)
    );
`else
    assign STALL_CNT = '0;
`endif

    // The encoding leaves value 3 unused; it must never be reached.
    assert property (@(posedge CLK) OCCUPANCY != 2'd3);

endmodule
